// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and frame helpers for TX and RX
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        TX_IDLE     = 3'd0,
        TX_START    = 3'd1,
        TX_DATA     = 3'd2,
        TX_PAR      = 3'd3,
        TX_STOP     = 3'd4,
        TX_BRK      = 3'd5,
        TX_BRK_MARK = 3'd6
    } tx_state_t;

    // Widest payload supported; narrower words are zero-extended, which leaves parity unchanged
    localparam int MAX_DATA_BITS = 9;

    function automatic int frame_bits(input int data_bits, input parity_t parity, input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input parity_t parity);
        case (parity)
            PARITY_EVEN: return ^data;
            PARITY_ODD:  return ~^data;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_ctr.sv
// rtl/uart_baud_ctr.sv - bit-time counter emitting a one-cycle pulse at the end of each bit
module uart_baud_ctr #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic sresetn,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..CLKS_PER_BIT-1 and wrap; clear holds the phase at zero so the first bit is full length
    always_ff @(posedge clk) begin
        if (!sresetn || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_end = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised UART transmitter with parity, stop bits and break
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115_200,
    parameter int          DATA_BITS = 8,
    parameter parity_t     PARITY    = PARITY_NONE,
    parameter int          STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 sresetn,
    input  logic                 serial_ready,
    input  logic                 send_break,
    output logic                 serial_data,
    output logic                 busy,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tvalid,
    input  logic [DATA_BITS-1:0] s_axis_tdata
);

    localparam int CLKS_PER_BIT = int'(CLK_FREQ / BAUD_RATE);
    localparam int FRAME_BITS   = frame_bits(DATA_BITS, PARITY, STOP_BITS);
    localparam int IDX_W        = $clog2(FRAME_BITS + 1);

    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_BRK  = IDX_W'(FRAME_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_frame: CLKS_PER_BIT must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_frame: DATA_BITS must be in 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
    endgenerate

    tx_state_t              state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   line_q, line_d;
    logic                   accept;
    logic                   bit_end;
    logic                   baud_clear;

    assign s_axis_tready = (state_q == TX_IDLE) && serial_ready && !send_break && sresetn;
    assign accept        = s_axis_tready && s_axis_tvalid;
    assign busy          = sresetn && (state_q != TX_IDLE);
    // Line is forced idle-high combinationally so it rises the moment reset asserts
    assign serial_data   = line_q || !sresetn;
    assign baud_clear    = (state_q == TX_IDLE);

    uart_baud_ctr #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_ctr (
        .clk    (clk),
        .sresetn(sresetn),
        .clear  (baud_clear),
        .bit_end(bit_end)
    );

    // State and bit-index registers
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q <= TX_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: break wins in IDLE, every other state advances on bit boundaries only
    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE: begin
                if (send_break && serial_ready) begin
                    state_d = TX_BRK;
                end else if (accept) begin
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) state_d = TX_DATA;
            end
            TX_DATA: begin
                if (bit_end && idx_q == LAST_DATA) begin
                    state_d = (PARITY != PARITY_NONE) ? TX_PAR : TX_STOP;
                end
            end
            TX_PAR: begin
                if (bit_end) state_d = TX_STOP;
            end
            TX_STOP: begin
                if (bit_end && idx_q == LAST_STOP) state_d = TX_IDLE;
            end
            TX_BRK: begin
                if (bit_end && idx_q == LAST_BRK) state_d = TX_BRK_MARK;
            end
            TX_BRK_MARK: begin
                if (bit_end) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase

        if (state_d != state_q) begin
            idx_d = '0;
        end else if (bit_end) begin
            idx_d = idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end
    end

    // Outputs: capture word and parity on accept, shift per data bit, and pick the next line level
    always_comb begin
        shreg_d = shreg_q;
        par_d   = par_q;
        line_d  = 1'b1;
        if (accept) begin
            shreg_d = s_axis_tdata;
            par_d   = parity_bit(MAX_DATA_BITS'(s_axis_tdata), PARITY);
        end else if (state_q == TX_DATA && bit_end) begin
            shreg_d = shreg_q >> 1;
        end
        case (state_d)
            TX_START, TX_BRK: line_d = 1'b0;
            TX_DATA:          line_d = shreg_d[0];
            TX_PAR:           line_d = par_d;
            default:          line_d = 1'b1;
        endcase
    end

    // Datapath registers; the line is registered so each bit starts cleanly on a clock edge
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            shreg_q <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
        end else begin
            shreg_q <= shreg_d;
            par_q   <= par_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It adds configurable data width, an optional parity bit (odd or even), one or two stop bits, break generation and a busy flag. It sits between an AXI-Stream byte source and the serial TX pin. Transmit start is gated by the `serial_ready` flow-control input.

## Interface
- `CLK_FREQ`, default 100e6: clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s.
  - `CLKS_PER_BIT = CLK_FREQ/BAUD_RATE`, integer division.
  - Elaboration error if `CLKS_PER_BIT < 2`.
- `DATA_BITS`, default 8: payload width. Legal range 5..9, else elaboration error.
- `PARITY`, default `PARITY_NONE`: one of `PARITY_NONE`, `PARITY_ODD`, `PARITY_EVEN` (`uart_pkg::parity_t`).
- `STOP_BITS`, default 1: legal values 1 or 2.
- `clk  in  1`: clock.
- `sresetn  in  1`: reset, synchronous, active-low; clock `clk`.
- `serial_ready  in  1`: far end clear to send. Gates frame start only.
- `send_break  in  1`: level request to transmit a break.
- `serial_data  out  1`: TX line, idle high.
- `busy  out  1`: high while a frame or break is in progress.
- `s_axis_tready  out  1`: AXI-Stream ready.
- `s_axis_tvalid  in  1`: AXI-Stream valid.
- `s_axis_tdata  in  DATA_BITS`: payload, LSB transmitted first.

## Operation
- **Frame format:** start bit (0), then `DATA_BITS` data bits LSB-first, then the parity bit if enabled, then `STOP_BITS` stop bits (1).
  - `FRAME_BITS = 1 + DATA_BITS + (PARITY != NONE) + STOP_BITS`.
- **Parity:**
  - EVEN: the parity bit makes the total count of ones across data+parity even, i.e. `^data`.
  - ODD: `~^data`.
  - Computed from the captured data word, not from the live bus.
- **States:** IDLE, START, DATA, PAR, STOP, BRK, BRK_MARK.
  - IDLE → START on accept.
  - START → DATA after 1 bit time.
  - DATA → PAR or STOP after `DATA_BITS` bit times.
  - PAR → STOP after 1 bit time.
  - STOP → IDLE after `STOP_BITS` bit times.
  - IDLE → BRK when `send_break` && `serial_ready`.
  - BRK → BRK_MARK after `FRAME_BITS` bit times, line low.
  - BRK_MARK → IDLE after 1 bit time, line high.
- **Handshake:**
  - `s_axis_tready = (state==IDLE) && serial_ready && !send_break && sresetn`.
  - Accept occurs when `tready && tvalid`; data is captured on that edge.
- **Priority:** `send_break` wins over pending data in IDLE. Data is not accepted while `send_break` is high.
- **Flow control:** `serial_ready` is sampled only in IDLE. Deasserting it mid-frame or mid-break does not abort the frame or break.
- **`send_break` sampling:** sampled only in IDLE. Deasserting it mid-break does not shorten the break.
- **Counters:**
  - Bit-time counter width `$clog2(CLKS_PER_BIT)`, counts 0..`CLKS_PER_BIT-1` and wraps to 0 at the end of each bit.
  - Bit index width `$clog2(FRAME_BITS+1)`.
  - Comparisons use explicitly width-cast constants.
- **`busy`:** `busy = (state != IDLE)`.

## Timing
- **Reset values:**
  - `serial_data = 1`. This is combinational, so the line is high while `sresetn` is low even with no clock edge.
  - `s_axis_tready = 0` and `busy = 0` while in reset.
- **Reset mid-frame:** the line goes high in the same cycle `sresetn` falls. The state returns to IDLE and nothing resumes.
- **Frame start latency:** registered `serial_data` drives the start bit from the cycle after the accept edge.
- **Bit duration:** every bit is exactly `CLKS_PER_BIT` cycles long.
- **End of frame:** the last stop bit ends and the state becomes IDLE. `tready` can be high in that IDLE cycle.
- **Back-to-back frames** (`tvalid` held, `serial_ready` high): accept-to-accept period is `FRAME_BITS*CLKS_PER_BIT + 1` cycles, including one extra idle-high cycle.
- **Break:** the line is low for exactly `FRAME_BITS*CLKS_PER_BIT` cycles, then high for `CLKS_PER_BIT` cycles. After that the state is IDLE.

## Structure
- **`uart_pkg`** holds:
  - the `parity_t` enum;
  - the `tx_state_t` enum;
  - the function `frame_bits(data_bits, parity, stop_bits)`;
  - the function `parity_bit(data, parity)`.
  - The future `uart_rx_frame` shares this package.
- **Sub-module `uart_baud_ctr`:**
  - Parameter `CLKS_PER_BIT`.
  - Inputs: `clk`, `sresetn`, `clear`.
  - Output: single-cycle `bit_end` pulse.
  - Reused by the RX side.
- **Top level:** FSM, shift register and parity register.

## Test plan
Bench parameters: `CLK_FREQ=100`, `BAUD_RATE=10`, so `CLKS_PER_BIT=10`.

- **8N1, send 0xA5:**
  - Line per 10-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - `busy` is high 100 cycles.
  - `tready` is high again 101 cycles after accept.
- **Parity, 8 data bits, send 0x07:**
  - EVEN gives parity bit 1; ODD gives 0.
  - With `DATA_BITS=7`, EVEN, data 0x7F: parity 1, `FRAME_BITS=10`.
- **8N2, back-to-back 0x00 then 0xFF with `tvalid` held:**
  - Stop high for 20 cycles.
  - Accept spacing is 111 cycles.
  - Second frame bits are correct.
- **Flow control:**
  - `serial_ready=0` with `tvalid=1` in IDLE: no accept and the line stays high.
  - Dropping `serial_ready` at data bit 3: the frame completes unchanged, and the next frame waits until `serial_ready=1`.
- **Break (8N1), `send_break` pulsed 1 cycle with `tvalid=1`:**
  - Line low for exactly 100 cycles, then high for 10.
  - Pending data is accepted only after that.
- **Reset during data bit 4:**
  - `serial_data=1` in the same cycle; `tready=0` and `busy=0` while in reset.
  - After release, a 0x3C frame is transmitted correctly with no residue from the aborted frame.
